tff_chain_monitor: RTL

Synchronous checker and decoder for the divided outputs of a T flip-flop ripple chain (Q1..QN). It reconstructs the chain's count value and verifies that every step is +1 (or −1) modulo 2^N. It also measures the full-cycle period in CLK cycles and reports lock and error status. It sits on the consuming side of the divider chain, as the receiving end that validates what the chain produces.

---
 rtl/tff_chain_monitor.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/tff_chain_monitor.sv
// Receiving-side checker for a T flip-flop ripple divider: rebuilds the chain count,
// validates each +1/-1 step modulo 2^N, measures the wrap period and reports lock/error status.
module tff_chain_monitor #(
    parameter int N      = 3,
    parameter int UP     = 1,
    parameter int SYNC   = 2,
    parameter int STABLE = 1,
    parameter int LOCK_N = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         clr_err_i,
    input  logic [N-1:0] q_in_i,
    output logic [N-1:0] count_o,
    output logic         valid_o,
    output logic         err_o,
    output logic [7:0]   err_cnt_o,
    output logic         locked_o,
    output logic [15:0]  period_o,
    output logic         period_vld_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACQ = 2'd1, TRACK = 2'd2, LOCK = 2'd3} state_t;

    localparam logic [N-1:0] STEP_ONE = {{(N-1){1'b0}}, 1'b1};
    localparam logic [2:0]   STABLE3  = 3'(STABLE);
    localparam logic [3:0]   LOCK_N4  = 4'(LOCK_N);

    state_t                 state_q, state_d, state_s;
    logic [SYNC-1:0][N-1:0] sync_q;
    logic [N-1:0]           prev_q, count_q, count_d, sync_s, exp_s;
    logic [2:0]             stab_q, stab_d;
    logic [3:0]             run_q, run_d, run_s;
    logic [7:0]             err_cnt_q, err_cnt_d, err_base_s;
    logic [15:0]            pcnt_q, pcnt_d, pcnt_s, pcnt_inc_s, period_q, period_d;
    logic                   valid_q, valid_d, err_q, err_d, locked_q, locked_d, locked_s;
    logic                   pvld_q, pvld_d, wrap_seen_q, wrap_seen_d;
    logic                   stable_s, accept_s, good_s, wrap_s;

    // Sample qualification: how long the synchronized value has been steady, and step decode
    always_comb begin
        sync_s     = sync_q[SYNC-1];
        stab_d     = (sync_s != prev_q) ? 3'd1 :
                     (stab_q >= STABLE3) ? STABLE3 : stab_q + 3'd1;
        stable_s   = (stab_d >= STABLE3);
        accept_s   = stable_s && (sync_s != count_q) && (state_q != IDLE);
        exp_s      = (UP != 0) ? count_q + STEP_ONE : count_q - STEP_ONE;
        good_s     = (sync_s == exp_s);
        wrap_s     = (sync_s == {N{1'b0}});
        pcnt_inc_s = (pcnt_q == 16'hFFFF) ? 16'hFFFF : pcnt_q + 16'd1;
        err_base_s = clr_err_i ? 8'd0 : err_cnt_q;
    end

    // Next-state and datapath; the error clear is applied before any new bad step
    always_comb begin
        state_s     = state_q;
        count_d     = count_q;
        valid_d     = 1'b0;
        err_d       = clr_err_i ? 1'b0 : err_q;
        err_cnt_d   = err_base_s;
        locked_s    = locked_q;
        run_s       = run_q;
        pcnt_s      = (state_q == IDLE) ? pcnt_q : pcnt_inc_s;
        period_d    = period_q;
        pvld_d      = 1'b0;
        wrap_seen_d = wrap_seen_q;
        case (state_q)
            IDLE: begin
                wrap_seen_d = 1'b0;
                state_s     = en_i ? ACQ : IDLE;
            end
            ACQ: begin
                if (accept_s) begin
                    count_d = sync_s;
                    valid_d = 1'b1;
                    state_s = TRACK;
                    run_s   = 4'd0;
                end else begin
                    state_s = ACQ;
                end
            end
            TRACK, LOCK: begin
                if (accept_s && good_s) begin
                    count_d = sync_s;
                    valid_d = 1'b1;
                    if ((state_q == TRACK) && (run_q + 4'd1 >= LOCK_N4)) begin
                        run_s    = run_q + 4'd1;
                        state_s  = LOCK;
                        locked_s = 1'b1;
                    end else if (state_q == TRACK) begin
                        run_s = run_q + 4'd1;
                    end else begin
                        state_s = LOCK;
                    end
                    // Only the second and later good wraps report; the first just aligns the counter
                    if (wrap_s) begin
                        pcnt_s      = 16'd0;
                        wrap_seen_d = 1'b1;
                        period_d    = wrap_seen_q ? pcnt_inc_s : period_q;
                        pvld_d      = wrap_seen_q;
                    end else begin
                        wrap_seen_d = wrap_seen_q;
                    end
                end else if (accept_s) begin
                    count_d   = sync_s;
                    valid_d   = 1'b1;
                    err_d     = 1'b1;
                    err_cnt_d = (err_base_s == 8'hFF) ? 8'hFF : err_base_s + 8'd1;
                    run_s     = 4'd0;
                    locked_s  = 1'b0;
                    state_s   = TRACK;
                    pcnt_s    = wrap_s ? 16'd0 : pcnt_s;
                end else begin
                    state_s = state_q;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        state_d  = en_i ? state_s : IDLE;
        locked_d = en_i ? locked_s : 1'b0;
        run_d    = en_i ? run_s : 4'd0;
        pcnt_d   = en_i ? pcnt_s : 16'd0;
    end

    // All state and output registers, synchronous active-high reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q      <= '0;
            prev_q      <= {N{1'b0}};
            stab_q      <= 3'd0;
            state_q     <= IDLE;
            count_q     <= {N{1'b0}};
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= 8'd0;
            locked_q    <= 1'b0;
            run_q       <= 4'd0;
            pcnt_q      <= 16'd0;
            period_q    <= 16'd0;
            pvld_q      <= 1'b0;
            wrap_seen_q <= 1'b0;
        end else begin
            sync_q[0] <= q_in_i;
            for (int i = 1; i < SYNC; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q      <= sync_s;
            stab_q      <= stab_d;
            state_q     <= state_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            locked_q    <= locked_d;
            run_q       <= run_d;
            pcnt_q      <= pcnt_d;
            period_q    <= period_d;
            pvld_q      <= pvld_d;
            wrap_seen_q <= wrap_seen_d;
        end
    end

    assign count_o      = count_q;
    assign valid_o      = valid_q;
    assign err_o        = err_q;
    assign err_cnt_o    = err_cnt_q;
    assign locked_o     = locked_q;
    assign period_o     = period_q;
    assign period_vld_o = pvld_q;
endmodule
